// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared single-precision float constants, field widths and helpers
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  // Working significand: hidden one, fraction, then guard/round/sticky.
  localparam int SIG_W  = FRAC_W + 4;

  localparam logic [31:0]      POS_INF_32 = 32'h7F80_0000;
  localparam logic [31:0]      NEG_INF_32 = 32'hFF80_0000;
  localparam logic [EXP_W-1:0] NAN_EXP_32 = 8'hFF;
  localparam logic [31:0]      QNAN       = 32'h7FC0_0000;

  function automatic logic [4:0] lead_zeros(input logic [SIG_W-1:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_align_shifter.sv
// rtl/fp32_align_shifter.sv - 27-bit right shift with sticky collapse and saturating amount
module fp32_align_shifter
  import fp32_pkg::*;
(
  input  logic [SIG_W-1:0] sig,
  input  logic [EXP_W-1:0] amt,
  output logic [SIG_W-1:0] shifted
);

  logic [SIG_W-1:0] kept;
  logic [SIG_W-1:0] mask;
  logic             sticky;

  always_comb begin
    kept    = '0;
    mask    = '0;
    sticky  = 1'b0;
    shifted = '0;
    if (amt >= EXP_W'(SIG_W)) begin
      shifted = {{(SIG_W-1){1'b0}}, |sig};
    end else begin
      kept    = sig >> amt;
      mask    = ~({SIG_W{1'b1}} << amt);
      sticky  = |(sig & mask);
      shifted = {kept[SIG_W-1:1], kept[0] | sticky};
    end
  end

endmodule

// File: rtl/fp32_add_unit.sv
// rtl/fp32_add_unit.sv - registered IEEE-754 single-precision adder, latency 1
module fp32_add_unit #(
  parameter logic [31:0] QNAN = fp32_pkg::QNAN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        nan_flag,
  output logic        overflow_flag
);

  import fp32_pkg::EXP_W;
  import fp32_pkg::FRAC_W;
  import fp32_pkg::SIG_W;
  import fp32_pkg::POS_INF_32;
  import fp32_pkg::NEG_INF_32;
  import fp32_pkg::NAN_EXP_32;
  import fp32_pkg::lead_zeros;

  localparam int SUM_W = SIG_W + 1;
  localparam int LO_W  = 14;
  localparam int HI_W  = SUM_W - LO_W;

  logic              a_s, b_s;
  logic [EXP_W-1:0]  a_e, b_e;
  logic [FRAC_W-1:0] a_f, b_f;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign {a_s, a_e, a_f} = a;
  assign {b_s, b_e, b_f} = b;
  assign a_nan  = (a_e == NAN_EXP_32) && (a_f != '0);
  assign b_nan  = (b_e == NAN_EXP_32) && (b_f != '0);
  assign a_inf  = (a_e == NAN_EXP_32) && (a_f == '0);
  assign b_inf  = (b_e == NAN_EXP_32) && (b_f == '0);
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);

  // Borrow out of the exponent subtract says B is the larger-exponent operand.
  logic [EXP_W:0]    ediff;
  logic              swap;
  logic              big_s;
  logic [EXP_W-1:0]  big_e;
  logic [FRAC_W-1:0] big_f, small_f;
  logic [EXP_W-1:0]  amt;
  logic [SIG_W-1:0]  big_sig, small_sig, small_al;

  assign ediff     = {1'b0, a_e} - {1'b0, b_e};
  assign swap      = ediff[EXP_W] | ((ediff == '0) && (b_f > a_f));
  assign big_s     = swap ? b_s : a_s;
  assign big_e     = swap ? b_e : a_e;
  assign big_f     = swap ? b_f : a_f;
  assign small_f   = swap ? a_f : b_f;
  assign amt       = swap ? (EXP_W'(0) - ediff[EXP_W-1:0]) : ediff[EXP_W-1:0];
  assign big_sig   = {1'b1, big_f, 3'b000};
  assign small_sig = {1'b1, small_f, 3'b000};

  fp32_align_shifter u_align (
    .sig     (small_sig),
    .amt     (amt),
    .shifted (small_al)
  );

  // Carry-select add; subtraction is big + ~small + 1, never negative.
  logic             sub;
  logic [SUM_W-1:0] op_x, op_y, sum;
  logic [LO_W:0]    lo_sum;
  logic [HI_W-1:0]  hi_c0, hi_c1;

  assign sub    = a_s ^ b_s;
  assign op_x   = {1'b0, big_sig};
  assign op_y   = sub ? ~{1'b0, small_al} : {1'b0, small_al};
  assign lo_sum = {1'b0, op_x[LO_W-1:0]} + {1'b0, op_y[LO_W-1:0]} + {{LO_W{1'b0}}, sub};
  assign hi_c0  = op_x[SUM_W-1:LO_W] + op_y[SUM_W-1:LO_W];
  assign hi_c1  = op_x[SUM_W-1:LO_W] + op_y[SUM_W-1:LO_W] + HI_W'(1);
  assign sum    = {lo_sum[LO_W] ? hi_c1 : hi_c0, lo_sum[LO_W-1:0]};

  logic [4:0]        lz;
  logic [SIG_W-1:0]  norm_mant;
  logic signed [9:0] norm_exp, fin_exp;
  logic              round_up;
  logic [FRAC_W+1:0] rounded;
  logic [FRAC_W-1:0] fin_frac;

  always_comb begin
    lz = lead_zeros(sum[SIG_W-1:0]);
    if (sum[SUM_W-1]) begin
      norm_mant = {sum[SUM_W-1:2], sum[1] | sum[0]};
      norm_exp  = $signed({2'b00, big_e}) + 10'sd1;
    end else begin
      norm_mant = sum[SIG_W-1:0] << lz;
      norm_exp  = $signed({2'b00, big_e}) - $signed({5'b00000, lz});
    end
    round_up = norm_mant[2] & (norm_mant[1] | norm_mant[0] | norm_mant[3]);
    rounded  = {1'b0, norm_mant[SIG_W-1:3]} + {{(FRAC_W+1){1'b0}}, round_up};
    if (rounded[FRAC_W+1]) begin
      fin_frac = rounded[FRAC_W:1];
      fin_exp  = norm_exp + 10'sd1;
    end else begin
      fin_frac = rounded[FRAC_W-1:0];
      fin_exp  = norm_exp;
    end
  end

  logic [31:0] res_c;
  logic        nan_c, ovf_c;

  always_comb begin
    res_c = '0;
    nan_c = 1'b0;
    ovf_c = 1'b0;
    if (a_nan || b_nan) begin
      res_c = QNAN;
      nan_c = 1'b1;
    end else if (a_inf && b_inf && (a_s != b_s)) begin
      res_c = QNAN;
      nan_c = 1'b1;
    end else if (a_inf) begin
      res_c = a;
    end else if (b_inf) begin
      res_c = b;
    end else if (a_zero && b_zero) begin
      res_c = {a_s & b_s, 31'b0};
    end else if (a_zero) begin
      res_c = b;
    end else if (b_zero) begin
      res_c = a;
    end else if (sum == '0) begin
      res_c = '0;
    end else if (fin_exp <= 10'sd0) begin
      res_c = {big_s, 31'b0};
    end else if (fin_exp >= 10'sd255) begin
      res_c = big_s ? NEG_INF_32 : POS_INF_32;
      ovf_c = 1'b1;
    end else begin
      res_c = {big_s, fin_exp[EXP_W-1:0], fin_frac};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      result        <= '0;
      nan_flag      <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result        <= res_c;
        nan_flag      <= nan_c;
        overflow_flag <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_fp32_add_unit.sv
// tb/tb_fp32_add_unit.sv - directed-vector self-checking bench for fp32_add_unit
module tb_fp32_add_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] result;
  logic        nan_flag;
  logic        overflow_flag;

  int n_tests = 0;
  int n_fail  = 0;

  fp32_add_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .a             (a),
    .b             (b),
    .out_valid     (out_valid),
    .result        (result),
    .nan_flag      (nan_flag),
    .overflow_flag (overflow_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_res,
                           input logic e_nan, input logic e_ovf);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".result"}, result, e_res);
    check({tag, ".nan"}, {31'b0, nan_flag}, {31'b0, e_nan});
    check({tag, ".ovf"}, {31'b0, overflow_flag}, {31'b0, e_ovf});
  endtask

  task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] e_res, input logic e_nan, input logic e_ovf);
    @(negedge clk);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_out(tag, e_res, e_nan, e_ovf);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(negedge clk);
    check("reset.valid", {31'b0, out_valid}, 32'd0);
    check("reset.result", result, 32'h0);
    check("reset.nan", {31'b0, nan_flag}, 32'd0);
    check("reset.ovf", {31'b0, overflow_flag}, 32'd0);
    rst = 1'b0;

    run_vec("one_plus_one",  32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
    run_vec("cancel",        32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000, 1'b0, 1'b0);
    run_vec("m3_plus_1",     32'hC040_0000, 32'h3F80_0000, 32'hC000_0000, 1'b0, 1'b0);
    run_vec("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1'b0);
    run_vec("nan_in",        32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 1'b0);
    run_vec("neg_inf",       32'hFF80_0000, 32'h4200_0000, 32'hFF80_0000, 1'b0, 1'b0);
    run_vec("pos_inf_b",     32'h4200_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0);
    run_vec("overflow",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b0, 1'b1);
    run_vec("tie_even",      32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0, 1'b0);
    run_vec("round_up",      32'h3F80_0000, 32'h3400_0000, 32'h3F80_0001, 1'b0, 1'b0);
    run_vec("tie_2p24",      32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 1'b0, 1'b0);
    run_vec("subnormal_b",   32'h3F80_0000, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0);
    run_vec("far_sticky",    32'h3F80_0000, 32'h2F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
    run_vec("renorm_sub",    32'h3F80_0000, 32'hBF7F_FFFF, 32'h3380_0000, 1'b0, 1'b0);
    run_vec("underflow",     32'h0080_0001, 32'h8080_0000, 32'h0000_0000, 1'b0, 1'b0);
    run_vec("neg_zeros",     32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    // Idle cycle: valid drops, result and flags keep their last value.
    @(negedge clk);
    check("hold.valid", {31'b0, out_valid}, 32'd0);
    check("hold.result", result, 32'h8000_0000);

    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h3F80_0000; in_valid = 1'b1;
    @(negedge clk);
    check_out("b2b0", 32'h4000_0000, 1'b0, 1'b0);
    a = 32'h3F80_0000; b = 32'h3F00_0000;
    @(negedge clk);
    check_out("b2b1", 32'h3FC0_0000, 1'b0, 1'b0);
    a = 32'hC040_0000; b = 32'h3F80_0000;
    @(negedge clk);
    check_out("b2b2", 32'hC000_0000, 1'b0, 1'b0);

    a = 32'h7F80_0000; b = 32'hFF80_0000; rst = 1'b1;
    @(negedge clk);
    check("rst_mid.valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid.result", result, 32'h0);
    check("rst_mid.nan", {31'b0, nan_flag}, 32'd0);
    check("rst_mid.ovf", {31'b0, overflow_flag}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
